// File: rtl/operand_issue_ctrl_pkg.sv
// ============================================================================
// Module  : operand_issue_ctrl_pkg
// Brief   : Shared types for the operand issue controller and its scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package operand_issue_ctrl_pkg;

    localparam int WORD_W = 32;
    localparam int CR_W   = 32;
    localparam int GPR_W  = 5;

    typedef logic [WORD_W-1:0] Word;
    typedef logic [CR_W-1:0]   Cr_bits;
    typedef logic [GPR_W-1:0]  Gpr_index;

    typedef struct packed {
        Word    a;
        Word    b;
        Word    c;
        logic   cin;
        Cr_bits cr;
    } Operands;

    // Decoded request as held while it works its way to the execute stage.
    typedef struct packed {
        Gpr_index ra;
        Gpr_index rb;
        Gpr_index rc;
        logic     use_a;
        logic     use_b;
        logic     use_c;
        logic     wr_en;
        Gpr_index rt;
    } Issue_req;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        READ_C  = 3'd2,
        CAPTURE = 3'd3,
        OUT     = 3'd4
    } Opissue_state;

    function automatic Operands operands_undef();
        return '0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/operand_issue_ctrl_scoreboard.sv
// ============================================================================
// Module  : operand_issue_ctrl_scoreboard
// Brief   : Pending-write bit per GPR with set-wins update and 3-source lookup.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_issue_ctrl_scoreboard
    import operand_issue_ctrl_pkg::*;
#(
    parameter int NUM_GPR = 32
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     set_en,
    input  Gpr_index set_idx,
    input  logic     clr_en,
    input  Gpr_index clr_idx,
    input  Gpr_index src_a,
    input  Gpr_index src_b,
    input  Gpr_index src_c,
    input  logic     use_a,
    input  logic     use_b,
    input  logic     use_c,
    output logic     hit
);

    logic [NUM_GPR-1:0] pending;
    logic [NUM_GPR-1:0] pending_next;

    // Set is applied after clear so a retiring old writer never hides a new one.
    always_comb begin
        pending_next = pending;
        for (int i = 0; i < NUM_GPR; i++) begin
            if (clr_en && (clr_idx == Gpr_index'(i))) pending_next[i] = 1'b0;
            if (set_en && (set_idx == Gpr_index'(i))) pending_next[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    // Lookup sees only registered bits: no same-cycle writeback bypass.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NUM_GPR; i++) begin
            if (pending[i]) begin
                if (use_a && (src_a == Gpr_index'(i))) hit = 1'b1;
                if (use_b && (src_b == Gpr_index'(i))) hit = 1'b1;
                if (use_c && (src_c == Gpr_index'(i))) hit = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/operand_issue_ctrl.sv
// ============================================================================
// Module  : operand_issue_ctrl
// Brief   : Single-thread operand fetch: hazard check, RF reads, operand issue.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_issue_ctrl
    import operand_issue_ctrl_pkg::*;
#(
    parameter int NUM_GPR        = 32,
    parameter bit USE_SCOREBOARD = 1'b1
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     req_valid,
    output logic     req_ready,
    input  Gpr_index req_ra,
    input  Gpr_index req_rb,
    input  Gpr_index req_rc,
    input  logic     req_use_a,
    input  logic     req_use_b,
    input  logic     req_use_c,
    input  logic     req_wr_en,
    input  Gpr_index req_rt,
    output Gpr_index rf_raddr_0,
    output Gpr_index rf_raddr_1,
    output logic     rf_re_0,
    output logic     rf_re_1,
    input  Word      rf_rdata_0,
    input  Word      rf_rdata_1,
    input  logic     xer_ca,
    input  Cr_bits   cr_in,
    output logic     op_valid,
    input  logic     op_ready,
    output Operands  opbus,
    input  logic     wb_valid,
    input  Gpr_index wb_rt,
    input  logic     flush,
    output logic     busy
);

    Opissue_state state;
    Opissue_state state_next;
    Issue_req     cur;
    Issue_req     req_in;
    Operands      opbus_q;
    logic         accept;
    logic         sb_set;
    logic         sb_hit;
    logic         hazard;

    assign req_in = '{ra: req_ra, rb: req_rb, rc: req_rc,
                      use_a: req_use_a, use_b: req_use_b, use_c: req_use_c,
                      wr_en: req_wr_en, rt: req_rt};

    operand_issue_ctrl_scoreboard #(
        .NUM_GPR (NUM_GPR)
    ) u_sb (
        .clk     (clk),
        .reset   (reset),
        .set_en  (sb_set),
        .set_idx (cur.rt),
        .clr_en  (wb_valid),
        .clr_idx (wb_rt),
        .src_a   (cur.ra),
        .src_b   (cur.rb),
        .src_c   (cur.rc),
        .use_a   (cur.use_a),
        .use_b   (cur.use_b),
        .use_c   (cur.use_c),
        .hit     (sb_hit)
    );

    assign hazard = USE_SCOREBOARD && sb_hit;

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rf_raddr_0 = '0;
        rf_raddr_1 = '0;
        rf_re_0    = 1'b0;
        rf_re_1    = 1'b0;
        op_valid   = 1'b0;
        sb_set     = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = CHECK;
            end
            CHECK: begin
                if (!hazard) begin
                    rf_raddr_0 = cur.ra;
                    rf_raddr_1 = cur.rb;
                    rf_re_0    = cur.use_a;
                    rf_re_1    = cur.use_b;
                    state_next = cur.use_c ? READ_C : CAPTURE;
                end
            end
            READ_C: begin
                rf_raddr_0 = cur.rc;
                rf_re_0    = 1'b1;
                state_next = CAPTURE;
            end
            CAPTURE: begin
                state_next = OUT;
            end
            OUT: begin
                op_valid  = 1'b1;
                req_ready = op_ready;
                if (op_ready) begin
                    sb_set     = cur.wr_en;
                    state_next = req_valid ? CHECK : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Flush overrides everything; the scoreboard only keeps retiring writebacks.
        if (flush) begin
            state_next = IDLE;
            req_ready  = 1'b0;
            op_valid   = 1'b0;
            rf_re_0    = 1'b0;
            rf_re_1    = 1'b0;
            rf_raddr_0 = '0;
            rf_raddr_1 = '0;
            sb_set     = 1'b0;
        end
    end

    assign accept = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cur     <= '0;
            opbus_q <= operands_undef();
        end else begin
            state <= state_next;
            if (accept) cur <= req_in;
            if (!flush) begin
                unique case (state)
                    READ_C: begin
                        opbus_q.a   <= cur.use_a ? rf_rdata_0 : '0;
                        opbus_q.b   <= cur.use_b ? rf_rdata_1 : '0;
                        opbus_q.c   <= '0;
                        opbus_q.cin <= xer_ca;
                        opbus_q.cr  <= cr_in;
                    end
                    CAPTURE: begin
                        // use_c means READ_C already took a/b/cin/cr.
                        if (cur.use_c) begin
                            opbus_q.c <= rf_rdata_0;
                        end else begin
                            opbus_q.a   <= cur.use_a ? rf_rdata_0 : '0;
                            opbus_q.b   <= cur.use_b ? rf_rdata_1 : '0;
                            opbus_q.c   <= '0;
                            opbus_q.cin <= xer_ca;
                            opbus_q.cr  <= cr_in;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign opbus = opbus_q;
    assign busy  = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_operand_issue_ctrl.sv
// ============================================================================
// Module  : tb_operand_issue_ctrl
// Brief   : Directed self-checking bench for operand_issue_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_issue_ctrl;
    import operand_issue_ctrl_pkg::*;

    logic     clk = 1'b0;
    logic     reset;
    logic     req_valid;
    logic     req_ready;
    Gpr_index req_ra, req_rb, req_rc, req_rt;
    logic     req_use_a, req_use_b, req_use_c, req_wr_en;
    Gpr_index rf_raddr_0, rf_raddr_1;
    logic     rf_re_0, rf_re_1;
    Word      rf_rdata_0, rf_rdata_1;
    logic     xer_ca;
    Cr_bits   cr_in;
    logic     op_valid;
    logic     op_ready;
    Operands  opbus;
    logic     wb_valid;
    Gpr_index wb_rt;
    logic     flush;
    logic     busy;

    int checks   = 0;
    int failures = 0;
    Word rf_mem [32];

    localparam Cr_bits CR_VAL = 32'h1234_5678;

    always #5 clk = ~clk;

    operand_issue_ctrl #(.NUM_GPR(32), .USE_SCOREBOARD(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ra(req_ra), .req_rb(req_rb), .req_rc(req_rc),
        .req_use_a(req_use_a), .req_use_b(req_use_b), .req_use_c(req_use_c),
        .req_wr_en(req_wr_en), .req_rt(req_rt),
        .rf_raddr_0(rf_raddr_0), .rf_raddr_1(rf_raddr_1),
        .rf_re_0(rf_re_0), .rf_re_1(rf_re_1),
        .rf_rdata_0(rf_rdata_0), .rf_rdata_1(rf_rdata_1),
        .xer_ca(xer_ca), .cr_in(cr_in),
        .op_valid(op_valid), .op_ready(op_ready), .opbus(opbus),
        .wb_valid(wb_valid), .wb_rt(wb_rt), .flush(flush), .busy(busy)
    );

    // Register file model: data one cycle after an enabled address.
    always @(posedge clk) begin
        if (rf_re_0) rf_rdata_0 <= rf_mem[rf_raddr_0];
        if (rf_re_1) rf_rdata_1 <= rf_mem[rf_raddr_1];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input Gpr_index ra, input Gpr_index rb, input Gpr_index rc,
                           input logic ua, input logic ub, input logic uc,
                           input logic wr, input Gpr_index rt);
        req_valid = 1'b1;
        req_ra = ra; req_rb = rb; req_rc = rc;
        req_use_a = ua; req_use_b = ub; req_use_c = uc;
        req_wr_en = wr; req_rt = rt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'hA000_0000 | i;
        rf_mem[1] = 32'h0101_0101; rf_mem[2] = 32'h0202_0202; rf_mem[3] = 32'h11;
        rf_mem[4] = 32'h22;        rf_mem[5] = 32'h0505_0505; rf_mem[7] = 32'h77;
        rf_rdata_0 = '0; rf_rdata_1 = '0;
        reset = 1'b1; req_valid = 1'b0; set_req(0, 0, 0, 0, 0, 0, 0, 0); req_valid = 1'b0;
        xer_ca = 1'b1; cr_in = CR_VAL; op_ready = 1'b1;
        wb_valid = 1'b0; wb_rt = '0; flush = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_op_valid", op_valid, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_re", {rf_re_0, rf_re_1}, 0);
        check("rst_raddr", {rf_raddr_0, rf_raddr_1}, 0);
        check("rst_opbus", opbus, 0);
        check("rst_sb", dut.u_sb.pending, 0);
        reset = 1'b0;

        // Two operands r3/r4, writes r12
        set_req(3, 4, 0, 1, 1, 0, 1, 12); #1;
        check("a_accept", req_ready, 1);
        tick(); req_valid = 1'b0; #1;
        check("a_raddr", {rf_raddr_0, rf_raddr_1}, {5'd3, 5'd4});
        check("a_re", {rf_re_0, rf_re_1}, 2'b11);
        tick();
        check("a_c2_valid", op_valid, 0);
        tick();
        check("a_c3_valid", op_valid, 1);
        check("a_ops", {opbus.a, opbus.b, opbus.c}, {32'h11, 32'h22, 32'h0});
        check("a_cin_cr", {opbus.cin, opbus.cr}, {1'b1, CR_VAL});
        tick();
        check("a_sb12", dut.u_sb.pending[12], 1);
        check("a_idle", busy, 0);

        // Three operands r1/r2/r5; cin sampled in READ_C
        set_req(1, 2, 5, 1, 1, 1, 0, 0); #1;
        tick(); req_valid = 1'b0; #1;
        check("b_raddr1", {rf_raddr_0, rf_raddr_1}, {5'd1, 5'd2});
        tick(); xer_ca = 1'b0; #1;
        check("b_raddr2", rf_raddr_0, 5);
        check("b_re2", {rf_re_0, rf_re_1}, 2'b10);
        tick(); xer_ca = 1'b1; #1;
        check("b_c3_valid", op_valid, 0);
        tick();
        check("b_c4_valid", op_valid, 1);
        check("b_ops_ab", {opbus.a, opbus.b}, {32'h0101_0101, 32'h0202_0202});
        check("b_ops_c", opbus.c, 32'h0505_0505);
        check("b_cin", opbus.cin, 0);
        tick();

        // RAW hazard on r7 cleared by a writeback
        set_req(3, 0, 0, 1, 0, 0, 1, 7); #1;
        tick(); req_valid = 1'b0; tick(); tick(); tick();
        check("h_sb7_set", dut.u_sb.pending[7], 1);
        set_req(7, 12, 0, 1, 0, 0, 0, 0); #1;
        tick(); req_valid = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            check("h_stall_re", {busy, rf_re_0, rf_re_1}, 3'b100);
            tick();
        end
        wb_valid = 1'b1; wb_rt = 7; #1;
        check("h_wb_cycle_re", rf_re_0, 0);
        tick(); wb_valid = 1'b0; #1;
        check("h_release", {rf_re_0, rf_raddr_0}, {1'b1, 5'd7});
        check("h_sb7_clr", dut.u_sb.pending[7], 0);
        tick();
        check("h_wb2_valid", op_valid, 0);
        tick();
        check("h_wb3_valid", op_valid, 1);
        check("h_a", opbus.a, 32'h77);
        tick();

        // Backpressure, same-cycle accept, set-wins on r9
        op_ready = 1'b0;
        set_req(3, 0, 0, 1, 0, 0, 1, 9); #1;
        tick(); req_valid = 1'b0; tick(); tick();
        check("p_out_valid", op_valid, 1);
        set_req(20, 0, 0, 1, 0, 0, 1, 20); #1;
        for (int i = 0; i < 5; i++) begin
            check("p_hold", {req_ready, op_valid, opbus.a}, {1'b0, 1'b1, 32'h11});
            tick();
        end
        op_ready = 1'b1; wb_valid = 1'b1; wb_rt = 9; #1;
        check("p_ready", req_ready, 1);
        tick(); req_valid = 1'b0; wb_valid = 1'b0; #1;
        check("p_sb9_setwins", dut.u_sb.pending[9], 1);
        check("p_new_check", {busy, rf_re_0, rf_raddr_0}, {1'b1, 1'b1, 5'd20});
        tick(); tick();
        check("p_new_out", {op_valid, opbus.a}, {1'b1, 32'hA000_0014});
        tick();
        check("p_sb20", dut.u_sb.pending[20], 1);

        // Flush in READ_C
        set_req(1, 2, 5, 1, 1, 1, 0, 0); #1;
        tick(); req_valid = 1'b0; tick();
        flush = 1'b1; set_req(3, 0, 0, 1, 0, 0, 0, 0); #1;
        check("f_no_accept", req_ready, 0);
        check("f_re", {rf_re_0, rf_re_1}, 0);
        tick(); flush = 1'b0; req_valid = 1'b0; #1;
        check("f_idle", {busy, op_valid}, 0);
        check("f_sb_kept", dut.u_sb.pending, (32'd1 << 9) | (32'd1 << 12) | (32'd1 << 20));
        tick();
        check("f_still_idle", busy, 0);

        // Reset while in OUT
        op_ready = 1'b0;
        set_req(3, 0, 0, 1, 0, 0, 0, 0); #1;
        tick(); req_valid = 1'b0; tick(); tick();
        check("r_out_valid", op_valid, 1);
        reset = 1'b1; #1;
        tick();
        check("r_after", {op_valid, busy, req_ready}, 3'b001);
        check("r_sb", dut.u_sb.pending, 0);
        check("r_opbus", opbus, 0);
        reset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
